serial_adder: RTL
=================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand and sum width in bits (legal 1..64).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: in_valid  input  1  operands a, b, cin presented.
REQ-005 SHALL have port: in_ready  output  1  block accepts operands this cycle.
REQ-006 SHALL have port: a  input  WIDTH  addend A, unsigned or two's complement.
REQ-007 SHALL have port: b  input  WIDTH  addend B.
REQ-008 SHALL have port: cin  input  1  carry-in to bit 0.
REQ-009 SHALL have port: out_valid  output  1  sum, cout (and ovf) valid.
REQ-010 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port: sum  output  WIDTH  (a+b+cin) mod 2^WIDTH.
REQ-012 SHALL have port: cout  output  1  carry out of bit WIDTH-1.
REQ-013 SHALL have port (only when OVF_EN macro defined): ovf  output  1  signed overflow.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 SHALL drive in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-016 SHALL accept operands when in_valid&&in_ready at a rising edge: latch a, b into shift registers, cin into carry flop, clear bit counter, go RUN.
REQ-017 SHALL ignore in_valid in RUN and DONE; no operand overwrite.
REQ-018 SHALL in RUN process exactly one bit per cycle, LSB first, through one full-adder slice: sum_bit = a^b^c, carry = ab|bc|ca.
REQ-019 SHALL shift each sum bit into the sum register MSB end so that after WIDTH RUN cycles sum[0] holds bit 0.
REQ-020 SHALL transition RUN->DONE on the edge processing bit WIDTH-1; out_valid rises exactly WIDTH cycles after the accepting edge.
REQ-021 SHALL hold sum, cout, ovf stable while out_valid=1 and out_ready=0 (unbounded backpressure).
REQ-022 SHALL transition DONE->IDLE on edge with out_ready=1; next accept earliest on following edge (throughput one add per WIDTH+2 cycles).
REQ-023 SHALL with WIDTH=1 spend one RUN cycle and produce the plain full-adder truth table.
REQ-024 SHALL size the bit counter as clog2(WIDTH)+1 bits; no wrap-around before terminal count.

Reset
REQ-025 SHALL, on rst=1 at a rising edge, force state IDLE, in_ready=1 next cycle, out_valid=0, sum=0, cout=0, ovf=0, counter=0.
REQ-026 SHALL abort any in-flight operation on reset mid-RUN or mid-DONE with no result emitted; rst takes priority over in_valid and out_ready.

Configuration
REQ-027 SHALL compile ovf logic and port only when SERIAL_ADDER_OVF_EN is defined; ovf = carry into bit WIDTH-1 XOR cout, captured at RUN->DONE.
REQ-028 SHALL without SERIAL_ADDER_OVF_EN omit the ovf port and flop; all other behaviour identical.

Structure
REQ-029 SHALL place FSM state enum (IDLE, RUN, DONE) and default WIDTH constant in shared package serial_adder_pkg.
REQ-030 SHALL instantiate the per-bit slice as sub-module fa_cell (inputs a, b, c; outputs sum, carry; purely combinational).

Verification
REQ-031 SHALL cover WIDTH=8: a=0x00, b=0x00, cin=0 -> out_valid 8 cycles after accept, sum=0x00, cout=0.
REQ-032 SHALL cover WIDTH=8: a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1; with SERIAL_ADDER_OVF_EN, ovf=0.
REQ-033 SHALL cover WIDTH=8 with SERIAL_ADDER_OVF_EN: a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1.
REQ-034 SHALL cover backpressure and busy: out_ready=0 for 5 cycles after out_valid -> sum held; new in_valid during RUN/DONE ignored; second add 0x10+0x20 after handshake -> 0x30.
REQ-035 SHALL cover reset mid-RUN: rst asserted 3 cycles after accept -> out_valid stays 0, in_ready=1 the cycle after reset, next add 0xFF+0x01+0 -> sum=0x00, cout=1.
REQ-036 SHALL cover WIDTH=1: all 8 (a,b,cin) combinations -> sum/cout match full-adder truth table, 1 cycle latency.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Optional feature macro: SERIAL_ADDER_OVF_EN (adds the signed-overflow flag).
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SA_WIDTH_DEFAULT = 8;

  // Bit counter must reach WIDTH-1 without wrapping, even for WIDTH=1.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder.
// Optional feature macro: SERIAL_ADDER_OVF_EN (adds the ovf signal).
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
`else
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );
`endif
endinterface

// File: rtl/serial_adder_fa_cell.sv
// Single-bit full-adder slice used once per RUN cycle by serial_adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (b & c) | (c & a);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice, LSB first, one bit per clock.
// Optional feature macro: SERIAL_ADDER_OVF_EN (signed-overflow flag on bus.ovf).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH_DEFAULT
) (
  input logic           clk,
  input logic           rst,
  serial_adder_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_shift;
  logic             cout_q;
  logic             s_bit;
  logic             c_bit;
  logic             accept;
  logic             last_bit;

  fa_cell u_fa (
    .a     (sh_a[0]),
    .b     (sh_b[0]),
    .c     (carry_q),
    .sum   (s_bit),
    .carry (c_bit)
  );

  assign accept   = (state_q == IDLE) && bus.in_valid;
  assign last_bit = (state_q == RUN) && (cnt_q == CW'(WIDTH - 1));

  // Sum bits enter at the MSB so bit 0 lands in sum_q[0] after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_sum_w1
      assign sum_shift = s_bit;
    end else begin : g_sum_wn
      assign sum_shift = {s_bit, sum_q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)  state_d = RUN;
      RUN:     if (last_bit)      state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
  end

  // Operand shifters and running carry: loaded on accept, shifted in RUN.
  always_ff @(posedge clk) begin
    if (accept) begin
      sh_a    <= bus.a;
      sh_b    <= bus.b;
      carry_q <= bus.cin;
    end else if (state_q == RUN) begin
      sh_a    <= sh_a >> 1;
      sh_b    <= sh_b >> 1;
      carry_q <= c_bit;
    end
  end

  // Visible result and bit counter; reset aborts any in-flight add.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (accept) begin
      cnt_q <= '0;
    end else if (state_q == RUN) begin
      cnt_q <= cnt_q + CW'(1);
      sum_q <= sum_shift;
      if (last_bit) begin
        cout_q <= c_bit;
      end
    end
  end

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q;

  // Carry into the MSB slice is carry_q while the last bit is processed.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (last_bit) begin
      ovf_q <= carry_q ^ c_bit;
    end
  end

  assign bus.ovf = ovf_q;
`endif

endmodule
